// File: rtl/prf_pkg.sv
// ============================================================================
// Module      : prf_pkg
// Description : Shared physical-register-file definitions: index width, lane
//               count, pointer-width helper and a small popcount helper.
//               Used by the release queue and by the freelist.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prf_pkg;

    localparam int PIDX_W = 6;
    localparam int NLANES = 4;
    localparam int CNT_W  = $clog2(NLANES + 1);

    typedef logic [PIDX_W-1:0] pidx_t;

    // Queue pointers carry one extra MSB so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [NLANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NLANES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_compact.sv
// ============================================================================
// Module      : lane_compact
// Description : Four-lane valid/data compactor. Valid lanes are packed toward
//               slot 0 in lane order (lane 0 oldest); vacant slots read zero.
//               Also returns the number of valid lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_compact
    import prf_pkg::*;
#(
    parameter int W = PIDX_W
) (
    input  logic [NLANES-1:0]        i_vld,
    input  logic [NLANES-1:0][W-1:0] i_data,
    output logic [NLANES-1:0][W-1:0] o_data,
    output logic [CNT_W-1:0]         o_cnt
);

    localparam int C_IW = $clog2(NLANES);

    // Walk lanes oldest-first, dropping each valid one into the next free slot.
    always_comb begin
        o_data = '0;
        o_cnt  = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (i_vld[i]) begin
                o_data[o_cnt[C_IW-1:0]] = i_data[i];
                o_cnt = o_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prf_release_queue.sv
// ============================================================================
// Module      : prf_release_queue
// Description : Program-order queue of previous-mapping pidx values. Rename
//               enqueues up to four per cycle; retirement commits them; up to
//               RLS_PER_CYC committed entries per cycle are registered onto
//               the freelist release lanes. A flush drops every uncommitted
//               entry while the committed backlog keeps draining.
//               Optional build macro RLS_ZERO_FILTER_EN: popped entries whose
//               pidx is 0 are consumed but their release lane stays low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prf_release_queue #(
    parameter int PIDX_W      = prf_pkg::PIDX_W,
    parameter int DEPTH       = 32,
    parameter int RLS_PER_CYC = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_enq_0,
    input  logic                    io_enq_1,
    input  logic                    io_enq_2,
    input  logic                    io_enq_3,
    input  logic [PIDX_W-1:0]       io_enq_pidx_0,
    input  logic [PIDX_W-1:0]       io_enq_pidx_1,
    input  logic [PIDX_W-1:0]       io_enq_pidx_2,
    input  logic [PIDX_W-1:0]       io_enq_pidx_3,
    output logic                    io_enq_rdy,
    input  logic                    io_cmt_0,
    input  logic                    io_cmt_1,
    input  logic                    io_cmt_2,
    input  logic                    io_cmt_3,
    input  logic                    io_flush,
    output logic                    io_rls_0,
    output logic                    io_rls_1,
    output logic                    io_rls_2,
    output logic                    io_rls_3,
    output logic [PIDX_W-1:0]       io_rls_pidx_0,
    output logic [PIDX_W-1:0]       io_rls_pidx_1,
    output logic [PIDX_W-1:0]       io_rls_pidx_2,
    output logic [PIDX_W-1:0]       io_rls_pidx_3,
    output logic                    io_empty,
    output logic [$clog2(DEPTH):0]  io_count
);

    import prf_pkg::*;

    localparam int              C_AW      = $clog2(DEPTH);
    localparam int              C_PW      = ptr_width(DEPTH);
    localparam int              C_SW      = C_PW + 1;
    localparam logic [C_PW-1:0] C_RDY_MAX = C_PW'(DEPTH - NLANES);
    localparam logic [C_PW-1:0] C_RLS_MAX = C_PW'(RLS_PER_CYC);

    // Storage and pointer state
    logic [PIDX_W-1:0]              r_mem [DEPTH];
    logic [C_PW-1:0]                r_head;
    logic [C_PW-1:0]                r_tail;
    logic [C_PW-1:0]                r_pend;
    logic [NLANES-1:0]              r_rls;
    logic [NLANES-1:0][PIDX_W-1:0]  r_rls_pidx;

    // Combinational datapath
    logic [NLANES-1:0]              w_enq;
    logic [NLANES-1:0]              w_cmt;
    logic [NLANES-1:0][PIDX_W-1:0]  w_enq_pidx;
    logic [NLANES-1:0][PIDX_W-1:0]  w_cmp_pidx;
    logic [CNT_W-1:0]               w_enq_cnt;
    logic [CNT_W-1:0]               w_cmt_cnt;
    logic [C_PW-1:0]                w_count;
    logic                           w_enq_rdy;
    logic                           w_enq_acc;
    logic [C_SW-1:0]                w_sum;
    logic [C_PW-1:0]                w_avail;
    logic [C_PW-1:0]                w_pop;
    logic [C_PW-1:0]                w_head_nx;
    logic [C_PW-1:0]                w_tail_nx;
    logic [C_PW-1:0]                w_pend_nx;
    logic [NLANES-1:0][C_PW-1:0]    w_wr_ptr;
    logic [NLANES-1:0][C_PW-1:0]    w_rd_ptr;
    logic [NLANES-1:0]              w_rls_nx;
    logic [NLANES-1:0][PIDX_W-1:0]  w_rls_pidx_nx;

    assign w_enq      = {io_enq_3, io_enq_2, io_enq_1, io_enq_0};
    assign w_cmt      = {io_cmt_3, io_cmt_2, io_cmt_1, io_cmt_0};
    assign w_enq_pidx = {io_enq_pidx_3, io_enq_pidx_2, io_enq_pidx_1, io_enq_pidx_0};

    lane_compact #(
        .W      (PIDX_W)
    ) u_enq_compact (
        .i_vld  (w_enq),
        .i_data (w_enq_pidx),
        .o_data (w_cmp_pidx),
        .o_cnt  (w_enq_cnt)
    );

    // Occupancy and ready both come from registered pointers only, so rename
    // never sees a combinational path from this cycle's pops.
    assign w_count   = r_tail - r_head;
    assign w_enq_rdy = (w_count <= C_RDY_MAX);
    assign w_enq_acc = w_enq_rdy & ~io_flush;

    // Committed-and-waiting total, never allowed past the entries actually held.
    assign w_cmt_cnt = popcnt(w_cmt);
    assign w_sum     = {1'b0, r_pend} + C_SW'(w_cmt_cnt);
    assign w_avail   = (w_sum > {1'b0, w_count}) ? w_count : w_sum[C_PW-1:0];
    assign w_pop     = (w_avail > C_RLS_MAX) ? C_RLS_MAX : w_avail;

    assign w_head_nx = r_head + w_pop;
    assign w_pend_nx = w_avail - w_pop;

    // On flush the tail snaps back to just past the last committed entry,
    // which also discards anything offered for enqueue in the same cycle.
    assign w_tail_nx = io_flush  ? (r_head + w_avail) :
                       w_enq_acc ? (r_tail + C_PW'(w_enq_cnt)) :
                                   r_tail;

    // Per-lane write and read pointers relative to tail and head.
    always_comb begin
        w_wr_ptr = '0;
        w_rd_ptr = '0;
        for (int i = 0; i < NLANES; i++) begin
            w_wr_ptr[i] = r_tail + C_PW'(i);
            w_rd_ptr[i] = r_head + C_PW'(i);
        end
    end

    // Pick the oldest w_pop entries for the release lanes, oldest on lane 0.
    always_comb begin
        w_rls_nx      = '0;
        w_rls_pidx_nx = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (C_PW'(i) < w_pop) begin
                w_rls_pidx_nx[i] = r_mem[w_rd_ptr[i][C_AW-1:0]];
                w_rls_nx[i]      = 1'b1;
`ifdef RLS_ZERO_FILTER_EN
                // x0 mapping is never returned to the freelist; lane stays put.
                if (w_rls_pidx_nx[i] == '0) begin
                    w_rls_nx[i] = 1'b0;
                end
`endif
            end
        end
    end

    // Compacted enqueue lanes land at tail, tail+1, ...; storage is not reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NLANES; i++) begin
            if (w_enq_acc && (CNT_W'(i) < w_enq_cnt)) begin
                r_mem[w_wr_ptr[i][C_AW-1:0]] <= w_cmp_pidx[i];
            end
        end
    end

    // Pointer, backlog and registered release-lane state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_pend     <= '0;
            r_rls      <= '0;
            r_rls_pidx <= '0;
        end else begin
            r_head     <= w_head_nx;
            r_tail     <= w_tail_nx;
            r_pend     <= w_pend_nx;
            r_rls      <= w_rls_nx;
            r_rls_pidx <= w_rls_pidx_nx;
        end
    end

`ifndef SYNTHESIS
    // Interface protocol checks on the rename and retire sides.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!((|w_enq) && !w_enq_rdy))
                else $error("prf_release_queue: enqueue offered while not ready");
            assert (w_sum <= {1'b0, w_count})
                else $error("prf_release_queue: commit exceeds uncommitted entries");
        end
    end
`endif

    assign io_enq_rdy    = w_enq_rdy;
    assign io_empty      = (w_count == '0) && (r_pend == '0);
    assign io_count      = w_count;
    assign io_rls_0      = r_rls[0];
    assign io_rls_1      = r_rls[1];
    assign io_rls_2      = r_rls[2];
    assign io_rls_3      = r_rls[3];
    assign io_rls_pidx_0 = r_rls_pidx[0];
    assign io_rls_pidx_1 = r_rls_pidx[1];
    assign io_rls_pidx_2 = r_rls_pidx[2];
    assign io_rls_pidx_3 = r_rls_pidx[3];

endmodule

`default_nettype wire
